// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg
//  Shared types and constants for the Wishbone master arbiter.
//  - arb_state_t : arbiter FSM state (IDLE, BUSY)
//  - MAX_MASTERS : largest supported number of requesting masters
//  - PTR_W       : width of a master index / last-served pointer
package wb_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int MAX_MASTERS = 4;
  localparam int PTR_W       = 2;

endpackage

// File: rtl/wb_arb_rr_picker.sv
// wb_arb_rr_picker
//  Combinational round-robin picker. Chooses the first requester after the
//  last-served index, wrapping around to index 0.
//  Ports:
//    req      in  NUM_MASTERS  request vector
//    last     in  PTR_W        index of the most recently served master
//    pick     out NUM_MASTERS  one-hot winner (0 when no request)
//    pick_idx out PTR_W        binary index of the winner
//    valid    out 1            at least one request present
module wb_arb_rr_picker
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [PTR_W-1:0]       last,
  output logic [NUM_MASTERS-1:0] pick,
  output logic [PTR_W-1:0]       pick_idx,
  output logic                   valid
);

  // Two ordered passes: first the masters above the last-served index, then
  // the wrapped-around ones from index 0 up to and including it.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    valid    = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!valid && req[i] && (i > int'(last))) begin
        valid    = 1'b1;
        pick[i]  = 1'b1;
        pick_idx = PTR_W'(i);
      end
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!valid && req[i] && (i <= int'(last))) begin
        valid    = 1'b1;
        pick[i]  = 1'b1;
        pick_idx = PTR_W'(i);
      end
    end
  end

endmodule

// File: rtl/wb_master_arbiter.sv
// wb_master_arbiter
//  Round-robin arbiter sharing one Wishbone slave port between NUM_MASTERS
//  masters. Grants whole bus cycles (cyc to cyc) with one idle cycle between
//  grants, and routes ack/err back to the granted master only.
//  Ports:
//    clk, rst                     clock, asynchronous active-high reset
//    m_cyc/m_stb/m_we             per-master controls (NUM_MASTERS bits)
//    m_addr/m_wdata/m_sel         flattened per-master address/data/selects
//    m_rdata                      slave read data broadcast to all masters
//    m_ack/m_err                  per-master responses, granted bit only
//    s_cyc/s_stb/s_we/s_addr/s_wdata/s_sel   slave-side request
//    s_rdata/s_ack/s_err          slave-side response
//    grant                        registered one-hot grant (0 = bus idle)
//  Optional feature: define WB_ARB_TIMEOUT_EN to add a response watchdog that
//  answers a stalled strobe with a one-cycle m_err after TIMEOUT_CYCLES.
module wb_master_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_MASTERS-1:0]          m_cyc,
  input  logic [NUM_MASTERS-1:0]          m_stb,
  input  logic [NUM_MASTERS-1:0]          m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_sel,
  output logic [DATA_W-1:0]               m_rdata,
  output logic [NUM_MASTERS-1:0]          m_ack,
  output logic [NUM_MASTERS-1:0]          m_err,
  output logic                            s_cyc,
  output logic                            s_stb,
  output logic                            s_we,
  output logic [ADDR_W-1:0]               s_addr,
  output logic [DATA_W-1:0]               s_wdata,
  output logic [DATA_W/8-1:0]             s_sel,
  input  logic [DATA_W-1:0]               s_rdata,
  input  logic                            s_ack,
  input  logic                            s_err,
  output logic [NUM_MASTERS-1:0]          grant
);

  localparam int SEL_W = DATA_W / 8;

  if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS) begin : g_chk_masters
    $error("NUM_MASTERS must be in 2..4");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_chk_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_t             state, state_nxt;
  logic [NUM_MASTERS-1:0] grant_nxt;
  logic [PTR_W-1:0]       last, last_nxt;
  logic [NUM_MASTERS-1:0] pick;
  logic [PTR_W-1:0]       pick_idx;
  logic                   pick_vld;
  logic                   stb_raw;
  logic                   to_fire;

  wb_arb_rr_picker #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_picker (
    .req     (m_cyc),
    .last    (last),
    .pick    (pick),
    .pick_idx(pick_idx),
    .valid   (pick_vld)
  );

  // State register: FSM state, grant and last-served pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      last  <= PTR_W'(NUM_MASTERS - 1);
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
    end
  end

  // Next-state logic. Releasing always passes through IDLE, which gives the
  // mandatory idle cycle between consecutive grants.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt = BUSY;
          grant_nxt = pick;
          last_nxt  = pick_idx;
        end
      end
      BUSY: begin
        if ((grant & m_cyc) == '0) begin
          state_nxt = IDLE;
          grant_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  assign stb_raw = |(grant & m_stb & m_cyc);

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt;

  // A slave response in the limit cycle wins over the watchdog error.
  assign to_fire = stb_raw && !s_ack && !s_err
                   && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if ((grant_nxt != grant) || s_ack || s_err || to_fire) begin
      to_cnt <= '0;
    end else if (stb_raw) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign to_fire = 1'b0;
`endif

  // Output logic: slave-side mux on the registered grant; with grant=0 every
  // slave-side output is 0 and slave responses are dropped.
  always_comb begin
    s_we    = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    s_sel   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant[i]) begin
        s_we    = m_we[i];
        s_addr  = m_addr[i*ADDR_W +: ADDR_W];
        s_wdata = m_wdata[i*DATA_W +: DATA_W];
        s_sel   = m_sel[i*SEL_W +: SEL_W];
      end
    end
    s_cyc   = |(grant & m_cyc);
    s_stb   = stb_raw & ~to_fire;
    m_ack   = grant & {NUM_MASTERS{s_ack}};
    m_err   = grant & {NUM_MASTERS{s_err | to_fire}};
    m_rdata = s_rdata;
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
module tb_wb_master_arbiter;

  localparam int N = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    m_cyc = '0, m_stb = '0, m_we;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N*DW/8-1:0] m_sel;
  logic [DW-1:0]   m_rdata;
  logic [N-1:0]    m_ack, m_err, grant;
  logic            s_cyc, s_stb, s_we;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [DW/8-1:0] s_sel;
  logic [DW-1:0]   s_rdata = 32'h12345678;
  logic            s_ack = 1'b0, s_err = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_master_arbiter #(
    .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_sel(m_sel),
    .m_rdata(m_rdata), .m_ack(m_ack), .m_err(m_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_sel(s_sel),
    .s_rdata(s_rdata), .s_ack(s_ack), .s_err(s_err),
    .grant(grant)
  );

  typedef struct {
    logic [1:0]  cyc, stb;
    logic        ack, err;
    logic [1:0]  g;
    logic        scyc, sstb;
    logic [1:0]  mack, merr;
    logic [31:0] saddr;
    logic        swe;
  } vec_t;

  vec_t va[15];
  vec_t vb[19];

  function automatic vec_t mk(logic [1:0] cyc, logic [1:0] stb, logic ack, logic err,
                              logic [1:0] g, logic scyc, logic sstb, logic [1:0] mack,
                              logic [1:0] merr, logic [31:0] saddr, logic swe);
    vec_t v;
    v.cyc = cyc; v.stb = stb; v.ack = ack; v.err = err; v.g = g; v.scyc = scyc;
    v.sstb = sstb; v.mack = mack; v.merr = merr; v.saddr = saddr; v.swe = swe;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input string tag, input int i, input vec_t v);
    @(negedge clk);
    m_cyc = v.cyc; m_stb = v.stb; s_ack = v.ack; s_err = v.err;
    #1;
    chk($sformatf("%s%0d grant", tag, i), 64'(grant), 64'(v.g));
    chk($sformatf("%s%0d s_cyc", tag, i), 64'(s_cyc), 64'(v.scyc));
    chk($sformatf("%s%0d s_stb", tag, i), 64'(s_stb), 64'(v.sstb));
    chk($sformatf("%s%0d m_ack", tag, i), 64'(m_ack), 64'(v.mack));
    chk($sformatf("%s%0d m_err", tag, i), 64'(m_err), 64'(v.merr));
    chk($sformatf("%s%0d s_addr", tag, i), 64'(s_addr), 64'(v.saddr));
    chk($sformatf("%s%0d s_we", tag, i), 64'(s_we), 64'(v.swe));
    chk($sformatf("%s%0d m_rdata", tag, i), 64'(m_rdata), 64'h12345678);
  endtask

  initial begin
    bit got;
    m_we    = 2'b01;
    m_addr  = {32'h0000_0020, 32'h0000_0010};
    m_wdata = {32'h5A5A_5A5A, 32'hA5A5_A5A5};
    m_sel   = {4'h3, 4'hF};

    // Single master, read routing, ignored responses while idle, err pass-through.
    va[0]  = mk(2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 32'h00, 0);
    va[1]  = mk(2'b01, 2'b01, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 32'h00, 0);
    va[2]  = mk(2'b01, 2'b01, 1, 0, 2'b01, 1, 1, 2'b01, 2'b00, 32'h10, 1);
    va[3]  = mk(2'b00, 2'b00, 0, 0, 2'b01, 0, 0, 2'b00, 2'b00, 32'h10, 1);
    va[4]  = mk(2'b00, 2'b00, 1, 0, 2'b00, 0, 0, 2'b00, 2'b00, 32'h00, 0);
    va[5]  = mk(2'b11, 2'b11, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 32'h00, 0);
    va[6]  = mk(2'b11, 2'b11, 1, 0, 2'b10, 1, 1, 2'b10, 2'b00, 32'h20, 0);
    va[7]  = mk(2'b11, 2'b11, 1, 0, 2'b10, 1, 1, 2'b10, 2'b00, 32'h20, 0);
    va[8]  = mk(2'b01, 2'b01, 0, 0, 2'b10, 0, 0, 2'b00, 2'b00, 32'h20, 0);
    va[9]  = mk(2'b01, 2'b01, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 32'h00, 0);
    va[10] = mk(2'b01, 2'b01, 1, 0, 2'b01, 1, 1, 2'b01, 2'b00, 32'h10, 1);
    va[11] = mk(2'b01, 2'b00, 0, 0, 2'b01, 1, 0, 2'b00, 2'b00, 32'h10, 1);
    va[12] = mk(2'b01, 2'b01, 0, 1, 2'b01, 1, 1, 2'b00, 2'b01, 32'h10, 1);
    va[13] = mk(2'b00, 2'b00, 0, 0, 2'b01, 0, 0, 2'b00, 2'b00, 32'h10, 1);
    va[14] = mk(2'b00, 2'b00, 0, 1, 2'b00, 0, 0, 2'b00, 2'b00, 32'h00, 0);

    // From reset: contention 01,10,01 with idle cycles, then a 3-beat burst by master0.
    vb[0]  = mk(2'b11, 2'b11, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 32'h00, 0);
    vb[1]  = mk(2'b11, 2'b11, 1, 0, 2'b01, 1, 1, 2'b01, 2'b00, 32'h10, 1);
    vb[2]  = mk(2'b11, 2'b11, 1, 0, 2'b01, 1, 1, 2'b01, 2'b00, 32'h10, 1);
    vb[3]  = mk(2'b10, 2'b10, 0, 0, 2'b01, 0, 0, 2'b00, 2'b00, 32'h10, 1);
    vb[4]  = mk(2'b11, 2'b11, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 32'h00, 0);
    vb[5]  = mk(2'b11, 2'b11, 1, 0, 2'b10, 1, 1, 2'b10, 2'b00, 32'h20, 0);
    vb[6]  = mk(2'b11, 2'b11, 1, 0, 2'b10, 1, 1, 2'b10, 2'b00, 32'h20, 0);
    vb[7]  = mk(2'b01, 2'b01, 0, 0, 2'b10, 0, 0, 2'b00, 2'b00, 32'h20, 0);
    vb[8]  = mk(2'b11, 2'b11, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 32'h00, 0);
    vb[9]  = mk(2'b11, 2'b11, 1, 0, 2'b01, 1, 1, 2'b01, 2'b00, 32'h10, 1);
    vb[10] = mk(2'b11, 2'b10, 0, 0, 2'b01, 1, 0, 2'b00, 2'b00, 32'h10, 1);
    vb[11] = mk(2'b11, 2'b11, 1, 0, 2'b01, 1, 1, 2'b01, 2'b00, 32'h10, 1);
    vb[12] = mk(2'b11, 2'b10, 0, 0, 2'b01, 1, 0, 2'b00, 2'b00, 32'h10, 1);
    vb[13] = mk(2'b11, 2'b11, 1, 0, 2'b01, 1, 1, 2'b01, 2'b00, 32'h10, 1);
    vb[14] = mk(2'b10, 2'b10, 0, 0, 2'b01, 0, 0, 2'b00, 2'b00, 32'h10, 1);
    vb[15] = mk(2'b10, 2'b10, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 32'h00, 0);
    vb[16] = mk(2'b10, 2'b10, 1, 0, 2'b10, 1, 1, 2'b10, 2'b00, 32'h20, 0);
    vb[17] = mk(2'b00, 2'b00, 0, 0, 2'b10, 0, 0, 2'b00, 2'b00, 32'h20, 0);
    vb[18] = mk(2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 2'b00, 32'h00, 0);

    // Reset state, with a request and a slave ack present during reset.
    m_cyc = 2'b01; m_stb = 2'b01; s_ack = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst grant", 64'(grant), 64'h0);
    chk("rst s_cyc", 64'(s_cyc), 64'h0);
    chk("rst s_stb", 64'(s_stb), 64'h0);
    chk("rst s_we", 64'(s_we), 64'h0);
    chk("rst m_ack", 64'(m_ack), 64'h0);
    chk("rst s_addr", 64'(s_addr), 64'h0);
    m_cyc = '0; m_stb = '0; s_ack = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 15; i++) run_vec("A", i, va[i]);

    // Reset in the middle of master0's cycle; master1 would be next without it.
    @(negedge clk);
    m_cyc = 2'b01; m_stb = 2'b01;
    got = 1'b0;
    for (int k = 0; k < 5 && !got; k++) begin
      @(negedge clk); #1;
      if (grant == 2'b01) got = 1'b1;
    end
    chk("midrst grant wait", 64'(got), 64'h1);
    chk("midrst s_stb", 64'(s_stb), 64'h1);
    chk("midrst s_wdata", 64'(s_wdata), 64'hA5A5A5A5);
    chk("midrst s_sel", 64'(s_sel), 64'hF);
    #1 rst = 1'b1;
    #1;
    chk("midrst async s_cyc", 64'(s_cyc), 64'h0);
    chk("midrst async s_stb", 64'(s_stb), 64'h0);
    chk("midrst async grant", 64'(grant), 64'h0);
    @(negedge clk);
    rst = 1'b0; m_cyc = '0; m_stb = '0;

    for (int i = 0; i < 19; i++) run_vec("B", i, vb[i]);

`ifdef WB_ARB_TIMEOUT_EN
    // Stalled slave: one watchdog error in the 8th strobe cycle.
    @(negedge clk);
    m_cyc = 2'b01; m_stb = 2'b01; s_ack = 1'b0; s_err = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk); #1;
      chk($sformatf("to%0d m_err", k), 64'(m_err), (k == 7) ? 64'h1 : 64'h0);
      chk($sformatf("to%0d s_stb", k), 64'(s_stb), (k == 7) ? 64'h0 : 64'h1);
    end
    @(negedge clk); m_cyc = '0; m_stb = '0;
    @(negedge clk);
    @(negedge clk); m_cyc = 2'b01; m_stb = 2'b01;
    // Ack arriving in the limit cycle suppresses the watchdog error.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      s_ack = (k == 7);
      #1;
      chk($sformatf("toack%0d m_err", k), 64'(m_err), 64'h0);
      chk($sformatf("toack%0d m_ack", k), 64'(m_ack), (k == 7) ? 64'h1 : 64'h0);
    end
    @(negedge clk); s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    repeat (2) @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
